// File: rtl/coffee_plant_pkg.sv
// coffee_plant_pkg: panel FSM states and default plant thresholds shared by the
// plant model, the controller bench and the FPGA top.
package coffee_plant_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        PRESS      = 3'd2,
        POUR       = 3'd3,
        STOP       = 3'd4
    } panel_state_t;

    localparam int DEF_LEVEL_W     = 8;
    localparam int DEF_LEVEL_MAX   = 200;
    localparam int DEF_LEVEL_MIN   = 20;
    localparam int DEF_DRAIN_RATE  = 2;
    localparam int DEF_TEMP_W      = 8;
    localparam int DEF_AMBIENT     = 20;
    localparam int DEF_TEMP_SET    = 90;
    localparam int DEF_TEMP_MAX    = 100;
    localparam int DEF_HEAT_STEP   = 5;
    localparam int DEF_COOL_DIV    = 4;
    localparam int DEF_BREW_CYCLES = 30;
    localparam int DEF_CUP_W       = 8;

endpackage

// File: rtl/coffee_plant_model_sat_counter.sv
// plant_sat_counter: up/down counter with parallel load, clamped to [LO, HI].
// Priority is load, then up, then down.
module plant_sat_counter #(
    parameter int W       = 8,
    parameter int RST_VAL = 0,
    parameter int LO      = 0,
    parameter int HI      = 255,
    parameter int UP_STEP = 1,
    parameter int DN_STEP = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         up,
    input  logic         dn,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    logic [W:0]   sum;
    logic [W-1:0] nxt;

    // one extra bit so the upward step cannot wrap before the clamp
    always_comb begin
        sum = {1'b0, q} + (W+1)'(UP_STEP);
        nxt = load ? load_val
            : up   ? (sum > (W+1)'(HI) ? W'(HI) : sum[W-1:0])
            : dn   ? (q < W'(LO + DN_STEP) ? W'(LO) : q - W'(DN_STEP))
            : q;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) q <= W'(RST_VAL);
        else        q <= nxt;

endmodule

// File: rtl/coffee_plant_model.sv
// coffee_plant_model: tank, boiler and customer panel driving the far side of
// the coffee machine controller so it can run closed-loop.
module coffee_plant_model
    import coffee_plant_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
    parameter int LEVEL_MIN   = DEF_LEVEL_MIN,
    parameter int DRAIN_RATE  = DEF_DRAIN_RATE,
    parameter int TEMP_W      = DEF_TEMP_W,
    parameter int AMBIENT     = DEF_AMBIENT,
    parameter int TEMP_SET    = DEF_TEMP_SET,
    parameter int TEMP_MAX    = DEF_TEMP_MAX,
    parameter int HEAT_STEP   = DEF_HEAT_STEP,
    parameter int COOL_DIV    = DEF_COOL_DIV,
    parameter int BREW_CYCLES = DEF_BREW_CYCLES,
    parameter int CUP_W       = DEF_CUP_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               H,
    input  logic               G,
    input  logic               Brew,
    input  logic               Wait,
    input  logic               refill,
    input  logic               order,
    output logic               W,
    output logic               T,
    output logic               B,
    output logic               S,
    output logic               busy,
    output logic [LEVEL_W-1:0] level,
    output logic [TEMP_W-1:0]  temp,
    output logic [CUP_W-1:0]   cups_served
);

    localparam int DW  = $clog2(COOL_DIV + 1);
    localparam int PCW = $clog2(BREW_CYCLES + 2);

    panel_state_t   state;
    logic [DW-1:0]  div;
    logic [PCW-1:0] pour;
    logic           pending, full, cool, unused_wait;

    // Wait is a controller status line with no effect on the plant
    assign unused_wait = Wait;

    assign cool = !H && div == DW'(COOL_DIV - 1);

    always_ff @(posedge clock or negedge reset)
        if (!reset) div <= '0;
        else        div <= (H || cool) ? '0 : div + DW'(1);

    plant_sat_counter #(
        .W(LEVEL_W), .RST_VAL(0), .LO(0), .HI(LEVEL_MAX),
        .UP_STEP(1), .DN_STEP(DRAIN_RATE)
    ) u_level (
        .clock(clock), .reset(reset), .load(refill), .up(1'b0), .dn(Brew),
        .load_val(LEVEL_W'(LEVEL_MAX)), .q(level)
    );

    plant_sat_counter #(
        .W(TEMP_W), .RST_VAL(AMBIENT), .LO(AMBIENT), .HI(TEMP_MAX),
        .UP_STEP(HEAT_STEP), .DN_STEP(1)
    ) u_temp (
        .clock(clock), .reset(reset), .load(1'b0), .up(H), .dn(cool),
        .load_val('0), .q(temp)
    );

    assign W    = level >= LEVEL_W'(LEVEL_MIN);
    assign T    = temp >= TEMP_W'(TEMP_SET);
    assign B    = state == PRESS;
    assign S    = state == STOP;
    assign busy = state != IDLE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pour        <= '0;
            pending     <= 1'b0;
            full        <= 1'b0;
            cups_served <= '0;
        end else begin
            // a fresh order in the IDLE-exit cycle survives the clear
            pending <= order || (pending && state != IDLE);
            case (state)
                IDLE:       if (pending) state <= WAIT_READY;
                WAIT_READY: if (G) state <= PRESS;
                PRESS: begin
                    if (Brew) begin
                        state <= POUR;
                        pour  <= PCW'(1);
                    end else if (!G) begin
                        state <= WAIT_READY;
                    end
                end
                POUR: begin
                    if (pour >= PCW'(BREW_CYCLES) || !W) begin
                        state <= STOP;
                        full  <= pour >= PCW'(BREW_CYCLES);
                    end else if (Brew) begin
                        pour <= pour + PCW'(1);
                    end
                end
                STOP: begin
                    if (!Brew) begin
                        state       <= IDLE;
                        cups_served <= cups_served + CUP_W'(full);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coffee_plant_model.sv
// tb_coffee_plant_model: directed and random plant checks against an integer
// reference, plus closed-loop brewing against a one-edge-lag controller.
module tb_coffee_plant_model;

    logic       clock, reset, H, G, Brew, Wait, refill, order;
    logic       W, T, B, S, busy;
    logic [7:0] level, temp, cups_served;

    int checks = 0, errors = 0;
    int m_level, m_temp, m_run;
    int brew_edges, b_cycles, s_cycles, s_rises;
    logic s_prev;
    logic ctl_on, n_h, n_g, n_brew, n_wait;

    coffee_plant_model dut (
        .clock(clock), .reset(reset), .H(H), .G(G), .Brew(Brew), .Wait(Wait),
        .refill(refill), .order(order), .W(W), .T(T), .B(B), .S(S),
        .busy(busy), .level(level), .temp(temp), .cups_served(cups_served)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_temp  = 20;
        m_run   = 0;
    endtask

    task automatic clear_counts();
        brew_edges = 0;
        b_cycles   = 0;
        s_cycles   = 0;
        s_rises    = 0;
        s_prev     = 1'b0;
    endtask

    // One clock: plant arithmetic on the inputs seen at the edge, then compare,
    // then let the bench controller apply what it registered at that edge.
    task automatic step();
        @(posedge clock);
        if (refill)    m_level = 200;
        else if (Brew) m_level = (m_level - 2 < 0) ? 0 : m_level - 2;
        if (H) begin
            m_temp = (m_temp + 5 > 100) ? 100 : m_temp + 5;
            m_run  = 0;
        end else begin
            m_run++;
            if (m_run % 4 == 0) m_temp = (m_temp - 1 < 20) ? 20 : m_temp - 1;
        end
        if (Brew) brew_edges++;
        #1;
        check("level", level, m_level);
        check("temp", temp, m_temp);
        check("W", W, m_level >= 20);
        check("T", T, m_temp >= 90);
        b_cycles += int'(B);
        s_cycles += int'(S);
        if (S && !s_prev) s_rises++;
        s_prev = S;
        refill = 1'b0;
        order  = 1'b0;
        if (ctl_on) begin
            H      = n_h;
            G      = n_g;
            Brew   = n_brew;
            Wait   = n_wait;
            n_h    = 1'b1;
            n_g    = W & T;
            n_brew = Brew ? !S : (B & G);
            n_wait = !W;
        end
    endtask

    task automatic ctl_start();
        ctl_on = 1'b1;
        n_h    = 1'b1;
        n_g    = 1'b0;
        n_brew = 1'b0;
        n_wait = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {H, G, Brew, Wait, refill, order, ctl_on} = '0;
        model_reset();
        clear_counts();
        #12;
        check("rst_level", level, 0);
        check("rst_temp", temp, 20);
        check("rst_WT", {W, T}, 0);
        check("rst_BS", {B, S, busy}, 0);
        check("rst_cups", cups_served, 0);
        @(negedge clock);
        reset = 1'b1;

        // heating ramp and cooling divider
        H = 1'b1;
        repeat (14) step();
        check("heat14_temp", temp, 90);
        check("heat14_T", T, 1);
        repeat (4) step();
        check("heat_sat", temp, 100);
        H = 1'b0;
        repeat (8) step();
        check("cool8", temp, 98);

        // refill, and refill beating a simultaneous drain
        refill = 1'b1;
        step();
        check("refill_level", level, 200);
        check("refill_W", W, 1);
        refill = 1'b1;
        Brew   = 1'b1;
        step();
        check("refill_vs_drain", level, 200);

        // reach level 150 / temp 95, then reset between edges
        H = 1'b1;
        repeat (25) step();
        Brew = 1'b0;
        H    = 1'b0;
        repeat (20) step();
        check("pre_rst_level", level, 150);
        check("pre_rst_temp", temp, 95);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_level", level, 0);
        check("async_temp", temp, 20);
        check("async_WTBS", {W, T, B, S, busy}, 0);
        check("async_cups", cups_served, 0);
        @(negedge clock);
        reset = 1'b1;

        // open-loop random plant exercise; panel must stay idle
        for (int i = 0; i < 300; i++) begin
            H      = 1'($urandom_range(0, 1));
            Brew   = 1'($urandom_range(0, 1));
            refill = ($urandom_range(0, 15) == 0);
            step();
            check("rand_idle", {B, S, busy}, 0);
        end

        // closed loop: one full cup from a full tank
        ctl_start();
        refill = 1'b1;
        step();
        repeat (20) step();
        clear_counts();
        order = 1'b1;
        step();
        for (int i = 0; i < 50 && !busy; i++) step();
        check("cup1_start", busy, 1);
        for (int i = 0; i < 200 && busy; i++) step();
        check("cup1_done", busy, 0);
        check("cup1_cups", cups_served, 1);
        check("cup1_level", level, 136);
        check("cup1_brew_edges", brew_edges, 32);
        check("cup1_b_cycles", b_cycles, 2);
        check("cup1_s_cycles", s_cycles, 2);

        // short cup: tank runs low during the pour
        ctl_on = 1'b0;
        H      = 1'b1;
        G      = 1'b0;
        Brew   = 1'b1;
        for (int i = 0; i < 100 && m_level > 40; i++) step();
        Brew = 1'b0;
        check("short_pre_level", level, 40);
        ctl_start();
        repeat (3) step();
        clear_counts();
        order = 1'b1;
        step();
        for (int i = 0; i < 50 && !busy; i++) step();
        check("short_start", busy, 1);
        for (int i = 0; i < 200 && busy; i++) step();
        check("short_done", busy, 0);
        check("short_cups", cups_served, 1);
        check("short_level", level, 14);
        check("short_brew_edges", brew_edges, 13);
        check("short_s_cycles", s_cycles, 2);

        // two orders during a pour: exactly one more cup queued
        refill = 1'b1;
        step();
        repeat (3) step();
        clear_counts();
        order = 1'b1;
        step();
        for (int i = 0; i < 50 && !(Brew && busy); i++) step();
        check("dual_pouring", Brew && busy, 1);
        repeat (5) step();
        order = 1'b1;
        step();
        repeat (3) step();
        order = 1'b1;
        step();
        for (int i = 0; i < 200 && cups_served != 8'd2; i++) step();
        check("dual_first_cup", cups_served, 2);
        check("dual_gap_idle", busy, 0);
        step();
        check("dual_requeued", busy, 1);
        for (int i = 0; i < 200 && cups_served != 8'd3; i++) step();
        repeat (5) step();
        check("dual_cups", cups_served, 3);
        check("dual_idle", busy, 0);
        check("dual_brew_edges", brew_edges, 64);
        check("dual_stops", s_rises, 2);
        check("dual_level", level, 72);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
